conv_window_sequencer: RTL and testbench
========================================

# conv_window_sequencer

Address and control sequencer for the NPU's dual-lane convolution datapath. On a start pulse it walks a KxK kernel across an IMG_W x IMG_H input map stored row-major, two horizontally adjacent output positions at a time. Each cycle it issues the source-map read addresses for both lanes and one shared kernel read address, together with the MAC clear/last strobes. It then issues the write-back addresses for the two accumulated sums. It sits between the top-level start/config registers and the feature/kernel/result memories and MAC lanes.

## Interface
- ADDR_W, 10, memory address width
- IMG_W, 8, input map width in elements
- IMG_H, 8, input map height in elements
- K, 3, kernel edge size (KxK taps)

- i_clk  in  1  clock; all logic is rising-edge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  start pulse; sampled only in IDLE
- i_src1_start_addr  in  ADDR_W  base address of the input map
- i_kernal_start_addr  in  ADDR_W  base address of the kernel
- i_dest_start_addr  in  ADDR_W  base address of the output map
- i_stride  in  3  window stride; 0 is treated as 1
- o_rd_en  out  1  read strobe, valid on all three read addresses
- o_src_addr1  out  ADDR_W  lane-1 source read address
- o_src_addr2  out  ADDR_W  lane-2 source read address
- o_kernel_addr  out  ADDR_W  shared kernel read address
- o_mac_clr  out  1  first tap of a window; the MAC loads the product instead of accumulating
- o_mac_last  out  1  last tap of a window
- o_lane2_valid  out  1  lane 2 holds a real output for the current pair
- o_wr_en  out  1  write strobe for the results
- o_dest_addr1  out  ADDR_W  lane-1 result address
- o_dest_addr2  out  ADDR_W  lane-2 result address; write suppressed when !o_lane2_valid
- o_busy  out  1  high from LOAD through WRITE of the last pair
- o_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, READ, DRAIN, WRITE, DONE.
- IDLE -> LOAD on i_start. In LOAD, latch the three base addresses and the stride (0→1). Clear row_base, col_base, kr, kc and dest_ptr.
- LOAD -> READ.
- READ lasts K*K cycles, o_rd_en=1. Taps are ordered kr outer, kc inner, 0..K-1.
  - o_src_addr1 = src_base + (row_base+kr)*IMG_W + col_base + kc
  - o_src_addr2 = o_src_addr1 + stride
  - o_kernel_addr = kern_base + kr*K + kc
  - o_mac_clr=1 at tap (0,0); o_mac_last=1 at tap (K-1,K-1).
  - After the last tap -> DRAIN.
- DRAIN: one idle cycle covering the memory read latency. -> WRITE.
- WRITE: one cycle.
  - o_wr_en=1, o_dest_addr1=dest_ptr, o_dest_addr2=dest_ptr+1.
  - Then advance:
    - dest_ptr += 1 + o_lane2_valid
    - col_base += 2*stride
    - if col_base+K > IMG_W: col_base=0, row_base += stride
    - if row_base+K > IMG_H -> DONE, else -> READ
- o_lane2_valid = (col_base + stride + K <= IMG_W). It is held constant from READ through WRITE of a pair.
- DONE: o_done=1 for one cycle. -> IDLE.
- Arithmetic: all address sums are modulo 2^ADDR_W (wrap, no error). Internal counters are sized to hold IMG_W+2*7 without overflow.
- i_start while not in IDLE is ignored. i_start during the DONE cycle is also ignored.
- i_rst in any state forces IDLE on the next edge. There is no partial write-back and no o_done pulse.

## Timing
- Reset values: every output is 0, state is IDLE.
- Outputs are registered to the state. Addresses and strobes change only on clock edges.
- Consumer contract:
  - Read data returns 1 cycle after o_rd_en.
  - The datapath delays o_mac_clr and o_mac_last by one cycle to align them with the data.
  - Sums are final in the DRAIN+1 cycle, which is the cycle with o_wr_en.
- Per output pair: K*K + 2 cycles (READ + DRAIN + WRITE).
- Total latency: the first o_rd_en is 2 cycles after i_start is sampled. o_done follows the last WRITE by 1 cycle.
- o_src_addr*/o_kernel_addr/o_mac_* are 0 when o_rd_en=0. o_dest_addr* are 0 when o_wr_en=0.
- The first pair of a row always has lane 1 valid. Only lane 2 can be invalid, and only at the end of a row.

## Test plan
- Defaults, stride=1, src=0x000, kern=0x100, dest=0x200.
  - Expect 18 pairs, 36 writes, o_done 1+18*11+1=200 cycles after start.
  - First tap: addr1=0x000, addr2=0x001, kern=0x100.
  - Last write of the run: dest1=0x222, dest2=0x223.
- Stride=2: pairs at cols (0,2) and (4, lane2 invalid) on rows 0,2,4.
  - Expect 6 WRITE cycles, 9 valid outputs, final dest_ptr=dest_start+9.
- Stride=0 gives a sequence identical to stride=1.
- src_start=0x3FE, stride=1: first taps wrap to 0x3FE, 0x3FF, 0x000.
  - o_src_addr2 at the first tap = 0x3FF.
- Assert i_rst during the 5th READ cycle of the third pair.
  - Next cycle: all outputs 0 and no o_done pulse.
  - A new i_start restarts from the base addresses.
- Pulse i_start mid-run and during the DONE cycle.
  - Expect no restart and an unchanged address sequence.
  - Exactly one o_done per accepted start.

Source files
------------

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: walks a KxK kernel over an IMG_W x IMG_H row-major map,
// two horizontally adjacent output positions per pass, and issues the source/kernel
// read addresses, MAC clear/last strobes and the result write-back addresses.
module conv_window_sequencer #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned K      = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_src1_start_addr,
  input  logic [ADDR_W-1:0] i_kernal_start_addr,
  input  logic [ADDR_W-1:0] i_dest_start_addr,
  input  logic [2:0]        i_stride,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_src_addr1,
  output logic [ADDR_W-1:0] o_src_addr2,
  output logic [ADDR_W-1:0] o_kernel_addr,
  output logic              o_mac_clr,
  output logic              o_mac_last,
  output logic              o_lane2_valid,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_dest_addr1,
  output logic [ADDR_W-1:0] o_dest_addr2,
  output logic              o_busy,
  output logic              o_done
);

  // Counters must hold a position plus two maximum strides without overflow.
  localparam int unsigned MAX_DIM = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int unsigned CNT_W   = $clog2(MAX_DIM + 2 * 7 + 1);
  localparam int unsigned KW      = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_base_q, src_base_d;
  logic [ADDR_W-1:0]   kern_base_q, kern_base_d;
  logic [ADDR_W-1:0]   dest_base_q, dest_base_d;
  logic [ADDR_W-1:0]   dest_ptr_q, dest_ptr_d;
  logic [2:0]          stride_q, stride_d;
  logic [CNT_W-1:0]    row_q, row_d;
  logic [CNT_W-1:0]    col_q, col_d;
  logic [CNT_W-1:0]    col_step;
  logic [KW-1:0]       kr_q, kr_d;
  logic [KW-1:0]       kc_q, kc_d;
  logic                lane2_q, lane2_d;

  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   src1_q, src1_d;
  logic [ADDR_W-1:0]   src2_q, src2_d;
  logic [ADDR_W-1:0]   kaddr_q, kaddr_d;
  logic                clr_q, clr_d;
  logic                last_q, last_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   dst1_q, dst1_d;
  logic [ADDR_W-1:0]   dst2_q, dst2_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state, window walk and output values aligned to the next state.
  always_comb begin
    state_d     = state_q;
    src_base_d  = src_base_q;
    kern_base_d = kern_base_q;
    dest_base_d = dest_base_q;
    dest_ptr_d  = dest_ptr_q;
    stride_d    = stride_q;
    row_d       = row_q;
    col_d       = col_q;
    kr_d        = kr_q;
    kc_d        = kc_q;
    lane2_d     = lane2_q;
    rd_en_d     = 1'b0;
    src1_d      = '0;
    src2_d      = '0;
    kaddr_d     = '0;
    clr_d       = 1'b0;
    last_d      = 1'b0;
    wr_en_d     = 1'b0;
    dst1_d      = '0;
    dst2_d      = '0;
    col_step    = col_q + CNT_W'({stride_q, 1'b0});

    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_LOAD;
      end
      S_LOAD: begin
        src_base_d  = i_src1_start_addr;
        kern_base_d = i_kernal_start_addr;
        dest_base_d = i_dest_start_addr;
        stride_d    = (i_stride == 3'd0) ? 3'd1 : i_stride;
        row_d       = '0;
        col_d       = '0;
        kr_d        = '0;
        kc_d        = '0;
        dest_ptr_d  = '0;
        state_d     = S_READ;
      end
      S_READ: begin
        if (kc_q == KW'(K - 1)) begin
          kc_d = '0;
          if (kr_q == KW'(K - 1)) begin
            kr_d    = '0;
            state_d = S_DRAIN;
          end else begin
            kr_d = kr_q + KW'(1);
          end
        end else begin
          kc_d = kc_q + KW'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        dest_ptr_d = dest_ptr_q + ADDR_W'(lane2_q) + ADDR_W'(1);
        if (32'(col_step) + K > IMG_W) begin
          col_d = '0;
          row_d = row_q + CNT_W'(stride_q);
        end else begin
          col_d = col_step;
        end
        if (32'(row_d) + K > IMG_H) state_d = S_DONE;
        else                        state_d = S_READ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Read-side outputs for the tap that will be current in the next cycle.
    if (state_d == S_READ) begin
      rd_en_d = 1'b1;
      src1_d  = src_base_d + ADDR_W'((32'(row_d) + 32'(kr_d)) * IMG_W)
                + ADDR_W'(col_d) + ADDR_W'(kc_d);
      src2_d  = src1_d + ADDR_W'(stride_d);
      kaddr_d = kern_base_d + ADDR_W'(32'(kr_d) * K) + ADDR_W'(kc_d);
      clr_d   = (kr_d == '0) && (kc_d == '0);
      last_d  = (kr_d == KW'(K - 1)) && (kc_d == KW'(K - 1));
      // Lane-2 validity is decided once per pair and held until its write-back.
      if (state_q != S_READ) lane2_d = (32'(col_d) + 32'(stride_d) + K <= IMG_W);
    end

    if (state_d == S_WRITE) begin
      wr_en_d = 1'b1;
      dst1_d  = dest_base_q + dest_ptr_q;
      dst2_d  = dst1_d + ADDR_W'(1);
    end

    if ((state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_DONE)) lane2_d = 1'b0;

    busy_d = (state_d == S_LOAD) || (state_d == S_READ) ||
             (state_d == S_DRAIN) || (state_d == S_WRITE);
    done_d = (state_d == S_DONE);
  end

  // State, walk counters and registered outputs; reset returns everything to zero/IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      src_base_q  <= '0;
      kern_base_q <= '0;
      dest_base_q <= '0;
      dest_ptr_q  <= '0;
      stride_q    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      kr_q        <= '0;
      kc_q        <= '0;
      lane2_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      src1_q      <= '0;
      src2_q      <= '0;
      kaddr_q     <= '0;
      clr_q       <= 1'b0;
      last_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      dst1_q      <= '0;
      dst2_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_base_q  <= src_base_d;
      kern_base_q <= kern_base_d;
      dest_base_q <= dest_base_d;
      dest_ptr_q  <= dest_ptr_d;
      stride_q    <= stride_d;
      row_q       <= row_d;
      col_q       <= col_d;
      kr_q        <= kr_d;
      kc_q        <= kc_d;
      lane2_q     <= lane2_d;
      rd_en_q     <= rd_en_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      kaddr_q     <= kaddr_d;
      clr_q       <= clr_d;
      last_q      <= last_d;
      wr_en_q     <= wr_en_d;
      dst1_q      <= dst1_d;
      dst2_q      <= dst2_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_rd_en       = rd_en_q;
  assign o_src_addr1   = src1_q;
  assign o_src_addr2   = src2_q;
  assign o_kernel_addr = kaddr_q;
  assign o_mac_clr     = clr_q;
  assign o_mac_last    = last_q;
  assign o_lane2_valid = lane2_q;
  assign o_wr_en       = wr_en_q;
  assign o_dest_addr1  = dst1_q;
  assign o_dest_addr2  = dst2_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer: full runs at several strides/bases,
// address wrap, mid-run reset and ignored start pulses.
module tb_conv_window_sequencer;

  localparam int ADDR_W = 10;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int K      = 3;
  localparam int BUDGET = 2000;

  logic              i_clk;
  logic              i_rst;
  logic              i_start;
  logic [ADDR_W-1:0] i_src1_start_addr;
  logic [ADDR_W-1:0] i_kernal_start_addr;
  logic [ADDR_W-1:0] i_dest_start_addr;
  logic [2:0]        i_stride;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_src_addr1;
  logic [ADDR_W-1:0] o_src_addr2;
  logic [ADDR_W-1:0] o_kernel_addr;
  logic              o_mac_clr;
  logic              o_mac_last;
  logic              o_lane2_valid;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_dest_addr1;
  logic [ADDR_W-1:0] o_dest_addr2;
  logic              o_busy;
  logic              o_done;

  conv_window_sequencer #(
    .ADDR_W(ADDR_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)
  ) dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_start             (i_start),
    .i_src1_start_addr   (i_src1_start_addr),
    .i_kernal_start_addr (i_kernal_start_addr),
    .i_dest_start_addr   (i_dest_start_addr),
    .i_stride            (i_stride),
    .o_rd_en             (o_rd_en),
    .o_src_addr1         (o_src_addr1),
    .o_src_addr2         (o_src_addr2),
    .o_kernel_addr       (o_kernel_addr),
    .o_mac_clr           (o_mac_clr),
    .o_mac_last          (o_mac_last),
    .o_lane2_valid       (o_lane2_valid),
    .o_wr_en             (o_wr_en),
    .o_dest_addr1        (o_dest_addr1),
    .o_dest_addr2        (o_dest_addr2),
    .o_busy              (o_busy),
    .o_done              (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  wire [56:0] out_bus = {o_rd_en, o_src_addr1, o_src_addr2, o_kernel_addr, o_mac_clr,
                         o_mac_last, o_lane2_valid, o_wr_en, o_dest_addr1, o_dest_addr2,
                         o_busy, o_done};

  typedef struct {
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [ADDR_W-1:0] k;
    bit                clr;
    bit                last;
    bit                l2;
  } tap_t;

  typedef struct {
    logic [ADDR_W-1:0] d1;
    logic [ADDR_W-1:0] d2;
    bit                l2;
  } wr_t;

  tap_t exp_taps[$];
  wr_t  exp_wrs[$];

  int n_checks = 0;
  int n_errors = 0;

  // Per-run observations.
  int                done_cyc, first_rd_cyc, wr_cycles, valid_outs, busy_cycles;
  int                done_cnt, mism, quiet_viol;
  bit                timed_out;
  logic [ADDR_W-1:0] first_a1, first_a2, first_k, third_a1, last_d1, last_d2, a1_at_rst;
  bit                last_l2;
  logic [56:0]       zero_after_rst;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected tap/write stream, written as plain nested loops over output positions.
  task automatic build_expected(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] kern,
                                input logic [ADDR_W-1:0] dest, input logic [2:0] stride);
    int   s;
    int   ptr;
    bit   l2;
    tap_t t;
    wr_t  w;
    exp_taps.delete();
    exp_wrs.delete();
    s   = (stride == 3'd0) ? 1 : int'(stride);
    ptr = 0;
    for (int r = 0; r + K <= IMG_H; r += s) begin
      for (int c = 0; c + K <= IMG_W; c += 2 * s) begin
        l2 = (c + s + K <= IMG_W);
        for (int kr = 0; kr < K; kr++) begin
          for (int kc = 0; kc < K; kc++) begin
            t.a1   = ADDR_W'(int'(src) + (r + kr) * IMG_W + c + kc);
            t.a2   = ADDR_W'(int'(t.a1) + s);
            t.k    = ADDR_W'(int'(kern) + kr * K + kc);
            t.clr  = (kr == 0) && (kc == 0);
            t.last = (kr == K - 1) && (kc == K - 1);
            t.l2   = l2;
            exp_taps.push_back(t);
          end
        end
        w.d1 = ADDR_W'(int'(dest) + ptr);
        w.d2 = ADDR_W'(int'(dest) + ptr + 1);
        w.l2 = l2;
        exp_wrs.push_back(w);
        ptr += l2 ? 2 : 1;
      end
    end
  endtask

  task automatic note_diff(input int cyc);
    if (mism == 0) $display("  stream diff first seen at cycle %0d", cyc);
    mism++;
  endtask

  // One job: start in cycle 0, watch every cycle until o_done (or reset window), then a quiet window.
  task automatic run_job(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] kern,
                         input logic [ADDR_W-1:0] dest, input logic [2:0] stride,
                         input int rst_cyc, input int mid_start_cyc, input bit start_in_done);
    int cyc, rd_idx, wr_idx, last_tap_cyc;
    bit stop;
    build_expected(src, kern, dest, stride);
    done_cyc = -1; first_rd_cyc = -1; wr_cycles = 0; valid_outs = 0; busy_cycles = 0;
    done_cnt = 0; mism = 0; quiet_viol = 0; timed_out = 0;
    first_a1 = '0; first_a2 = '0; first_k = '0; third_a1 = '1; last_d1 = '0; last_d2 = '0;
    last_l2 = 0; a1_at_rst = '0; zero_after_rst = '1;
    rd_idx = 0; wr_idx = 0; last_tap_cyc = -10; stop = 0; cyc = 0;

    i_src1_start_addr   = src;
    i_kernal_start_addr = kern;
    i_dest_start_addr   = dest;
    i_stride            = stride;
    i_start             = 1'b1;

    while (!stop && cyc < BUDGET) begin
      @(posedge i_clk); #1;
      cyc++;
      i_start = 1'b0;
      i_rst   = 1'b0;
      if (o_busy) busy_cycles++;
      if (o_rd_en) begin
        if (first_rd_cyc < 0) begin
          first_rd_cyc = cyc;
          first_a1 = o_src_addr1; first_a2 = o_src_addr2; first_k = o_kernel_addr;
        end
        if (rd_idx == 2) third_a1 = o_src_addr1;
        if (rd_idx < exp_taps.size()) begin
          if (o_src_addr1 !== exp_taps[rd_idx].a1 || o_src_addr2 !== exp_taps[rd_idx].a2 ||
              o_kernel_addr !== exp_taps[rd_idx].k || o_mac_clr !== exp_taps[rd_idx].clr ||
              o_mac_last !== exp_taps[rd_idx].last || o_lane2_valid !== exp_taps[rd_idx].l2)
            note_diff(cyc);
        end else begin
          note_diff(cyc);
        end
        if (o_mac_last) last_tap_cyc = cyc;
        rd_idx++;
      end else if ((o_src_addr1 | o_src_addr2 | o_kernel_addr) != '0 || o_mac_clr || o_mac_last) begin
        note_diff(cyc);
      end
      if (o_wr_en) begin
        wr_cycles++;
        valid_outs += o_lane2_valid ? 2 : 1;
        last_d1 = o_dest_addr1; last_d2 = o_dest_addr2; last_l2 = o_lane2_valid;
        if (cyc != last_tap_cyc + 2) note_diff(cyc);
        if (wr_idx < exp_wrs.size()) begin
          if (o_dest_addr1 !== exp_wrs[wr_idx].d1 || o_dest_addr2 !== exp_wrs[wr_idx].d2 ||
              o_lane2_valid !== exp_wrs[wr_idx].l2)
            note_diff(cyc);
        end else begin
          note_diff(cyc);
        end
        wr_idx++;
      end else if ((o_dest_addr1 | o_dest_addr2) != '0) begin
        note_diff(cyc);
      end
      if (o_rd_en && o_wr_en) note_diff(cyc);
      if (cyc == rst_cyc) begin
        a1_at_rst = o_src_addr1;
        i_rst = 1'b1;
      end
      if (rst_cyc > 0 && cyc == rst_cyc + 1) zero_after_rst = out_bus;
      if (rst_cyc > 0 && cyc == rst_cyc + 8) stop = 1;
      if (cyc == mid_start_cyc) i_start = 1'b1;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        stop = 1;
        if (start_in_done) i_start = 1'b1;
      end
    end
    if (!stop) timed_out = 1;
    if (rst_cyc == 0 && !timed_out) begin
      if (rd_idx != exp_taps.size() || wr_idx != exp_wrs.size()) note_diff(cyc);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      i_rst   = 1'b0;
      if (o_done) done_cnt++;
      if (o_busy || o_rd_en || o_wr_en) quiet_viol++;
    end
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_stride = '0;
    i_src1_start_addr = '0; i_kernal_start_addr = '0; i_dest_start_addr = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check_eq("reset_outputs", 64'(out_bus), 64'd0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Defaults, stride 1.
    run_job(10'h000, 10'h100, 10'h200, 3'd1, 0, 0, 0);
    check_eq("s1_timeout",     64'(timed_out), 64'd0);
    check_eq("s1_stream",      64'(mism), 64'd0);
    check_eq("s1_done_cyc",    64'(done_cyc), 64'd200);
    check_eq("s1_first_rd",    64'(first_rd_cyc), 64'd2);
    check_eq("s1_wr_cycles",   64'(wr_cycles), 64'd18);
    check_eq("s1_valid_outs",  64'(valid_outs), 64'd36);
    check_eq("s1_first_a1",    64'(first_a1), 64'h000);
    check_eq("s1_first_a2",    64'(first_a2), 64'h001);
    check_eq("s1_first_k",     64'(first_k), 64'h100);
    check_eq("s1_last_d1",     64'(last_d1), 64'h222);
    check_eq("s1_last_d2",     64'(last_d2), 64'h223);
    check_eq("s1_busy_cycles", 64'(busy_cycles), 64'd199);
    check_eq("s1_done_cnt",    64'(done_cnt), 64'd1);
    check_eq("s1_quiet",       64'(quiet_viol), 64'd0);

    // Stride 2: pairs (0,2) and (4, lane 2 invalid) on rows 0, 2, 4.
    run_job(10'h000, 10'h100, 10'h200, 3'd2, 0, 0, 0);
    check_eq("s2_stream",      64'(mism), 64'd0);
    check_eq("s2_done_cyc",    64'(done_cyc), 64'd68);
    check_eq("s2_wr_cycles",   64'(wr_cycles), 64'd6);
    check_eq("s2_valid_outs",  64'(valid_outs), 64'd9);
    check_eq("s2_last_d1",     64'(last_d1), 64'h208);
    check_eq("s2_last_l2",     64'(last_l2), 64'd0);
    check_eq("s2_done_cnt",    64'(done_cnt), 64'd1);

    // Stride 0 behaves as stride 1.
    run_job(10'h000, 10'h100, 10'h200, 3'd0, 0, 0, 0);
    check_eq("s0_stream",      64'(mism), 64'd0);
    check_eq("s0_done_cyc",    64'(done_cyc), 64'd200);
    check_eq("s0_wr_cycles",   64'(wr_cycles), 64'd18);
    check_eq("s0_last_d1",     64'(last_d1), 64'h222);

    // Source base near the top of the address space wraps.
    run_job(10'h3FE, 10'h100, 10'h200, 3'd1, 0, 0, 0);
    check_eq("wrap_first_a1",  64'(first_a1), 64'h3FE);
    check_eq("wrap_first_a2",  64'(first_a2), 64'h3FF);
    check_eq("wrap_third_a1",  64'(third_a1), 64'h000);
    check_eq("wrap_stream",    64'(mism), 64'd0);

    // Reset during the 5th READ cycle of the third pair (cycle 28, tap kr=1 kc=1 at col 4).
    run_job(10'h000, 10'h100, 10'h200, 3'd1, 28, 0, 0);
    check_eq("rst_tap_a1",     64'(a1_at_rst), 64'h00D);
    check_eq("rst_outputs",    64'(zero_after_rst), 64'd0);
    check_eq("rst_no_done",    64'(done_cnt), 64'd0);
    check_eq("rst_stream",     64'(mism), 64'd0);

    // Restart after reset uses the new base addresses.
    run_job(10'h040, 10'h180, 10'h300, 3'd1, 0, 0, 0);
    check_eq("rs_stream",      64'(mism), 64'd0);
    check_eq("rs_first_a1",    64'(first_a1), 64'h040);
    check_eq("rs_first_k",     64'(first_k), 64'h180);
    check_eq("rs_done_cyc",    64'(done_cyc), 64'd200);
    check_eq("rs_done_cnt",    64'(done_cnt), 64'd1);

    // Start pulses mid-run and in the DONE cycle are ignored.
    run_job(10'h000, 10'h100, 10'h200, 3'd1, 0, 50, 1);
    check_eq("ign_stream",     64'(mism), 64'd0);
    check_eq("ign_done_cyc",   64'(done_cyc), 64'd200);
    check_eq("ign_done_cnt",   64'(done_cnt), 64'd1);
    check_eq("ign_quiet",      64'(quiet_viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
